mem_rr_arbiter: RTL and testbench

//   Two-client round-robin arbiter for the shared 8x8 memory (write, read, addr_w, addr_r, datain, dataout).

---
 rtl/mem_rr_arbiter_if.sv | 42 ++++
 rtl/mem_rr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arbiter_if.sv
// Bus bundle between the two datapath clients, the arbiter and the shared memory.
// master: the client/memory side (drives requests and memory read data).
// slave:  the arbiter.
interface mem_rr_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          err0;
    logic          err1;
    logic          mem_write;
    logic          mem_read;
    logic [AW-1:0] mem_addr_w;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_datain;
    logic [DW-1:0] mem_dataout;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        input  mem_write, mem_read, mem_addr_w, mem_addr_r, mem_datain
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        output mem_write, mem_read, mem_addr_w, mem_addr_r, mem_datain
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-client round-robin arbiter in front of the shared 8x8 memory.
// Grants are combinational on the current requests; read data and
// out-of-range errors come back RD_LAT+1 cycles after the grant, tagged
// to the requesting client, in grant order.
//
// state   | meaning
// PRIO_C0 | client 0 wins when both request (client 1 was granted last)
// PRIO_C1 | client 1 wins when both request (client 0 was granted last)
module mem_rr_arbiter #(
    parameter int DW        = 8,
    parameter int AW        = 3,
    parameter int MEM_DEPTH = 7,
    parameter int RD_LAT    = 1
) (
    input logic             clock,
    input logic             reset,
    mem_rr_arbiter_if.slave bus
);
    localparam logic [0:0]  PRIO_C0   = 1'b0;
    localparam logic [0:0]  PRIO_C1   = 1'b1;
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(MEM_DEPTH);

    logic [0:0]    prio;
    logic          gnt0;
    logic          gnt1;
    logic          any_gnt;
    logic          win_id;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          in_range;
    logic          rsp_vld;
    logic          rsp_err;

    // Response shift pipeline: {valid, client id, error}.
    logic          pipe_vld [RD_LAT];
    logic          pipe_id  [RD_LAT];
    logic          pipe_err [RD_LAT];
    logic          last_vld;
    logic          last_id;
    logic          last_err;

    logic          rvalid0_q;
    logic          rvalid1_q;
    logic          err0_q;
    logic          err1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    // Grant selection; held off entirely while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (bus.req0 && bus.req1) begin
                gnt0 = (prio == PRIO_C0);
                gnt1 = (prio == PRIO_C1);
            end else begin
                gnt0 = bus.req0;
                gnt1 = bus.req1;
            end
        end
    end

    // Winner's request fields and the response it will generate.
    always_comb begin
        any_gnt   = gnt0 | gnt1;
        win_id    = gnt1;
        win_we    = gnt1 ? bus.we1    : bus.we0;
        win_addr  = gnt1 ? bus.addr1  : bus.addr0;
        win_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
        in_range  = ({1'b0, win_addr} < DEPTH_LIM);
        rsp_vld   = any_gnt & (~win_we | ~in_range);
        rsp_err   = ~in_range;
    end

    // Memory port drive; unused address/data lanes are forced to zero.
    always_comb begin
        bus.mem_write  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_addr_w = '0;
        bus.mem_addr_r = '0;
        bus.mem_datain = '0;
        if (any_gnt && in_range) begin
            if (win_we) begin
                bus.mem_write  = 1'b1;
                bus.mem_addr_w = win_addr;
                bus.mem_datain = win_wdata;
            end else begin
                bus.mem_read   = 1'b1;
                bus.mem_addr_r = win_addr;
            end
        end
    end

    // Round-robin pointer: the client just granted loses the next tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            prio <= PRIO_C0;
        end else if (gnt0) begin
            prio <= PRIO_C1;
        end else if (gnt1) begin
            prio <= PRIO_C0;
        end
    end

    // Response pipeline; reset drops every in-flight entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_id[i]  <= 1'b0;
                pipe_err[i] <= 1'b0;
            end
        end else begin
            pipe_vld[0] <= rsp_vld;
            pipe_id[0]  <= win_id;
            pipe_err[0] <= rsp_err;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
                pipe_err[i] <= pipe_err[i-1];
            end
        end
    end

    assign last_vld = pipe_vld[RD_LAT-1];
    assign last_id  = pipe_id[RD_LAT-1];
    assign last_err = pipe_err[RD_LAT-1];

    // Final stage: capture memory data for the tagged client, pulse valid/err.
    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= last_vld & ~last_err & ~last_id;
            rvalid1_q <= last_vld & ~last_err &  last_id;
            err0_q    <= last_vld &  last_err & ~last_id;
            err1_q    <= last_vld &  last_err &  last_id;
            if (last_vld && !last_err && !last_id) begin
                rdata0_q <= bus.mem_dataout;
            end
            if (last_vld && !last_err && last_id) begin
                rdata1_q <= bus.mem_dataout;
            end
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.err0    = err0_q;
    assign bus.err1    = err1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: a behavioural memory, a transaction-level
// reference (last-granted client, reference memory contents, queue of
// expected responses with due cycle), directed scenarios then random traffic.
module tb_mem_rr_arbiter;
    localparam int DW = 8;
    localparam int AW = 3;

    typedef struct {
        int         due;
        bit         id;
        bit         err;
        logic [7:0] data;
    } rsp_t;

    logic clock;
    logic reset;
    logic tb_init;

    mem_rr_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    mem_rr_arbiter #(.DW(DW), .AW(AW), .MEM_DEPTH(7), .RD_LAT(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    bit         last_win;
    rsp_t       rq[$];
    logic [7:0] ref_mem [8];
    logic [7:0] mem_model [8];
    logic [7:0] exp_rd0;
    logic [7:0] exp_rd1;
    bit         exp_g0;
    bit         exp_g1;
    logic       obs_g0;
    logic       obs_g1;
    logic       obs_mw;
    logic [2:0] obs_maw;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural memory: registered read, one cycle latency.
    always @(posedge clock) begin
        if (tb_init) begin
            for (int i = 0; i < 8; i++) mem_model[i] <= 8'(i * 37 + 11);
            bus.mem_dataout <= 8'h00;
        end else begin
            if (bus.mem_write) mem_model[bus.mem_addr_w] <= bus.mem_datain;
            if (bus.mem_read) bus.mem_dataout <= mem_model[bus.mem_addr_r];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check combinational outputs at negedge against the
    // reference, advance the reference, then check registered outputs.
    task automatic cycle();
        bit         w, we, oor, g, rst_now;
        logic [2:0] a;
        logic [7:0] d;
        bit         ev0, ev1, ee0, ee1;
        @(negedge clock);
        rst_now = reset;
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        if (!reset) begin
            if (bus.req0 && bus.req1) begin
                exp_g0 = (last_win == 1'b1);
                exp_g1 = !exp_g0;
            end else begin
                exp_g0 = bus.req0;
                exp_g1 = bus.req1;
            end
        end
        g   = exp_g0 | exp_g1;
        w   = exp_g1;
        we  = w ? bus.we1 : bus.we0;
        a   = w ? bus.addr1 : bus.addr0;
        d   = w ? bus.wdata1 : bus.wdata0;
        oor = (int'(a) >= 7);
        obs_g0  = bus.gnt0;
        obs_g1  = bus.gnt1;
        obs_mw  = bus.mem_write;
        obs_maw = bus.mem_addr_w;
        chk("gnt0", bus.gnt0, exp_g0);
        chk("gnt1", bus.gnt1, exp_g1);
        chk("mem_write", bus.mem_write, g && we && !oor);
        chk("mem_read", bus.mem_read, g && !we && !oor);
        chk("mem_addr_w", bus.mem_addr_w, (g && we && !oor) ? a : 3'd0);
        chk("mem_addr_r", bus.mem_addr_r, (g && !we && !oor) ? a : 3'd0);
        chk("mem_datain", bus.mem_datain, (g && we && !oor) ? d : 8'd0);
        if (g) begin
            last_win = w;
            if (we && !oor) ref_mem[a] = d;
            if (!we || oor) rq.push_back('{due: cyc + 2, id: w, err: oor, data: oor ? 8'h00 : ref_mem[a]});
        end
        @(posedge clock);
        #1;
        cyc++;
        if (rst_now) begin
            rq.delete();
            exp_rd0  = 8'h00;
            exp_rd1  = 8'h00;
            last_win = 1'b1;
        end
        ev0 = 0; ev1 = 0; ee0 = 0; ee1 = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].err) begin
                if (rq[0].id) ee1 = 1; else ee0 = 1;
            end else if (rq[0].id) begin
                ev1 = 1; exp_rd1 = rq[0].data;
            end else begin
                ev0 = 1; exp_rd0 = rq[0].data;
            end
            void'(rq.pop_front());
        end
        chk("rvalid0", bus.rvalid0, ev0);
        chk("rvalid1", bus.rvalid1, ev1);
        chk("err0", bus.err0, ee0);
        chk("err1", bus.err1, ee1);
        chk("rdata0", bus.rdata0, exp_rd0);
        chk("rdata1", bus.rdata1, exp_rd1);
    endtask

    task automatic idle(input int n);
        bus.req0 = 0;
        bus.req1 = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1; tb_init = 1;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
        last_win = 1; exp_rd0 = 0; exp_rd1 = 0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'(i * 37 + 11);

        // Reset held with both requesting: no grants, outputs zero.
        cycle();
        cycle();
        chk("rst_no_gnt0", obs_g0, 1'b0);
        chk("rst_no_gnt1", obs_g1, 1'b0);
        chk("rst_rvalid0", bus.rvalid0, 1'b0);
        reset = 0; tb_init = 0;
        cycle();
        chk("release_gnt0_first", obs_g0, 1'b1);
        cycle();
        chk("release_gnt1_second", obs_g1, 1'b1);
        idle(2);

        // Client 0 write 0x05 to addr 5, then read it back.
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3'd5; bus.wdata0 = 8'h05;
        cycle();
        chk("wr5_mem_write", obs_mw, 1'b1);
        chk("wr5_mem_addr_w", obs_maw, 3'd5);
        bus.we0 = 0;
        cycle();
        chk("rd5_not_early", bus.rvalid0, 1'b0);
        bus.req0 = 0;
        cycle();
        chk("rd5_rvalid0", bus.rvalid0, 1'b1);
        chk("rd5_rdata0", bus.rdata0, 8'h05);
        idle(1);

        // Client 1 write and read to out-of-range addr 7.
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 3'd7; bus.wdata1 = 8'h04;
        cycle();
        chk("oor_wr_gnt1", obs_g1, 1'b1);
        chk("oor_wr_no_mem_write", obs_mw, 1'b0);
        bus.we1 = 0;
        cycle();
        chk("oor_wr_err1", bus.err1, 1'b1);
        bus.req1 = 0;
        cycle();
        chk("oor_rd_err1", bus.err1, 1'b1);
        chk("oor_rd_no_rvalid1", bus.rvalid1, 1'b0);
        idle(1);

        // Both clients hold req for 6 cycles: strict alternation from client 0.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3'd2;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 3'd3;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("alt_gnt0", obs_g0, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("alt_gnt1", obs_g1, (i % 2 == 0) ? 1'b0 : 1'b1);
        end
        idle(3);

        // Read granted, reset next cycle: response dropped, priority back to client 0.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3'd4;
        cycle();
        bus.req0 = 0; reset = 1;
        cycle();
        chk("flush_rvalid0_a", bus.rvalid0, 1'b0);
        chk("flush_err0_a", bus.err0, 1'b0);
        reset = 0;
        cycle();
        chk("flush_rvalid0_b", bus.rvalid0, 1'b0);
        chk("flush_err0_b", bus.err0, 1'b0);
        bus.req0 = 1; bus.addr0 = 3'd6; bus.req1 = 1; bus.addr1 = 3'd0;
        cycle();
        chk("post_rst_prio_gnt0", obs_g0, 1'b1);
        bus.req0 = 0;
        cycle();
        idle(3);

        // Write in t, other client reads same address in t+1.
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3'd1; bus.wdata0 = 8'h70;
        cycle();
        bus.req0 = 0; bus.req1 = 1; bus.we1 = 0; bus.addr1 = 3'd1;
        cycle();
        bus.req1 = 0;
        cycle();
        chk("raw_rvalid1", bus.rvalid1, 1'b1);
        chk("raw_rdata1", bus.rdata1, 8'h70);
        idle(2);

        // Random traffic; a client keeps its request stable until granted.
        for (int n = 0; n < 500; n++) begin
            if (!bus.req0 || exp_g0) begin
                bus.req0   = ($urandom_range(0, 3) != 0);
                bus.we0    = $urandom_range(0, 1) == 1;
                bus.addr0  = 3'($urandom_range(0, 7));
                bus.wdata0 = 8'($urandom);
            end
            if (!bus.req1 || exp_g1) begin
                bus.req1   = ($urandom_range(0, 3) != 0);
                bus.we1    = $urandom_range(0, 1) == 1;
                bus.addr1  = 3'($urandom_range(0, 7));
                bus.wdata1 = 8'($urandom);
            end
            reset = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reset = 0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
